// File: rtl/oto_pilot_gen2.sv
// rtl/oto_pilot_gen2.sv - altitude autopilot core with sensor fusion, hysteresis motor control and timed emergency
module oto_pilot_gen2 #(
    parameter int W          = 8,
    parameter int MIN_ALT    = 10,
    parameter int MAX_ALT    = 200,
    parameter int DIFF_THR   = 9,
    parameter int HYST       = 2,
    parameter int SETTLE_CYC = 4,
    parameter int FAULT_CYC  = 8,
    parameter int EMERG_CYC  = 16,
    parameter int MAX_RETRY  = 3,
    parameter int LAND_ALT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] gnss_i,
    input  logic [W-1:0] altimetre_i,
    input  logic [W-1:0] hedef_yukseklik_i,
    input  logic         yukseklik_bilgisi_i,
    input  logic         inis_i,
    output logic         motor_o,
    output logic         yesil_led_o,
    output logic         kirmizi_led_o,
    output logic [2:0]   state_o
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int FLT_W = (FAULT_CYC > 1) ? $clog2(FAULT_CYC) : 1;
    localparam int EMG_W = (EMERG_CYC > 1) ? $clog2(EMERG_CYC) : 1;
    localparam int RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    typedef enum logic [2:0] {
        BEKLE = 3'd0,
        UCUS  = 3'd1,
        TUTMA = 3'd2,
        INIS  = 3'd3,
        ACIL  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               motor_q, motor_d, yesil_q, yesil_d, kirmizi_q, kirmizi_d;
    logic [W-1:0]       target_q, target_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [FLT_W-1:0]   fault_q, fault_d;
    logic [EMG_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;

    logic [W-1:0] diff, fused;
    logic [W:0]   sum, hyst_top;
    logic         disagree, target_ok, strobe_ok, motor_hyst, settle_hit;
    logic         settle_done, fault_done, retry_done, timer_done;

    // Sum and hysteresis ceiling carry one extra bit so 255-class inputs never wrap.
    always_comb begin
        diff       = (gnss_i >= altimetre_i) ? gnss_i - altimetre_i : altimetre_i - gnss_i;
        sum        = {1'b0, gnss_i} + {1'b0, altimetre_i};
        disagree   = diff > W'(DIFF_THR);
        fused      = disagree ? gnss_i : sum[W:1];
        target_ok  = (hedef_yukseklik_i >= W'(MIN_ALT)) && (hedef_yukseklik_i <= W'(MAX_ALT));
        strobe_ok  = yukseklik_bilgisi_i && target_ok;
        hyst_top   = {1'b0, target_q} + (W+1)'(HYST);
        settle_hit = fused >= target_q;
        if (fused < target_q)
            motor_hyst = 1'b1;
        else if ({1'b0, fused} >= hyst_top)
            motor_hyst = 1'b0;
        else
            motor_hyst = motor_q;
        settle_done = settle_q == SET_W'(SETTLE_CYC - 1);
        fault_done  = fault_q == FLT_W'(FAULT_CYC - 1);
        retry_done  = retry_q == RTY_W'(MAX_RETRY - 1);
        timer_done  = timer_q == EMG_W'(EMERG_CYC - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= BEKLE;
            motor_q   <= 1'b0;
            yesil_q   <= 1'b0;
            kirmizi_q <= 1'b0;
            target_q  <= '0;
            settle_q  <= '0;
            fault_q   <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            motor_q   <= motor_d;
            yesil_q   <= yesil_d;
            kirmizi_q <= kirmizi_d;
            target_q  <= target_d;
            settle_q  <= settle_d;
            fault_q   <= fault_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BEKLE: begin
                if (strobe_ok)
                    state_d = UCUS;
                else if (yukseklik_bilgisi_i && retry_done)
                    state_d = ACIL;
            end
            UCUS, TUTMA: begin
                if (disagree && fault_done)
                    state_d = ACIL;
                else if (inis_i)
                    state_d = INIS;
                else if (strobe_ok)
                    state_d = UCUS;
                else if (state_q == UCUS && settle_hit && settle_done)
                    state_d = TUTMA;
            end
            INIS:    if (fused <= W'(LAND_ALT)) state_d = BEKLE;
            ACIL:    if (timer_done) state_d = BEKLE;
            default: state_d = BEKLE;
        endcase
    end

    always_comb begin
        motor_d   = 1'b0;
        yesil_d   = yesil_q;
        kirmizi_d = kirmizi_q;
        target_d  = target_q;
        settle_d  = '0;
        fault_d   = '0;
        timer_d   = '0;
        retry_d   = retry_q;
        case (state_q)
            BEKLE: begin
                if (strobe_ok) begin
                    target_d  = hedef_yukseklik_i;
                    retry_d   = '0;
                    kirmizi_d = 1'b0;
                    yesil_d   = 1'b0;
                end else if (yukseklik_bilgisi_i) begin
                    if (retry_done)
                        kirmizi_d = 1'b1;
                    else
                        retry_d = retry_q + 1'b1;
                end
            end
            UCUS, TUTMA: begin
                fault_d = disagree ? (fault_done ? fault_q : fault_q + 1'b1) : '0;
                if (disagree && fault_done) begin
                    kirmizi_d = 1'b1;
                end else if (inis_i) begin
                    yesil_d = 1'b0;
                end else if (strobe_ok) begin
                    motor_d  = motor_hyst;
                    target_d = hedef_yukseklik_i;
                    yesil_d  = 1'b0;
                end else begin
                    motor_d = motor_hyst;
                    if (state_q == TUTMA)
                        settle_d = settle_q;
                    else if (settle_hit && settle_done)
                        yesil_d = 1'b1;
                    else if (settle_hit)
                        settle_d = settle_q + 1'b1;
                end
            end
            ACIL: begin
                kirmizi_d = 1'b1;
                if (timer_done)
                    retry_d = '0;
                else
                    timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign motor_o       = motor_q;
    assign yesil_led_o   = yesil_q;
    assign kirmizi_led_o = kirmizi_q;
    assign state_o       = state_q;
endmodule
